ds_engine: RTL and testbench
============================

Name: ds_engine

Overview:
- 2x2 box-filter downsampler; the responder at the far end of the top controller's downsample run/done handshake.
- Started by a rising edge on run_i. Streams the source image out of the pixel ROM and writes a half-resolution image into the frame RAM.
- Returns a one-cycle done_o pulse when finished.
- Sits between the image ROM, the downsample frame RAM and the top-level sequencing FSM.

Parameters:
- IMG_W, 64, source width in pixels (even, >=2)
- IMG_H, 64, source height in pixels (even, >=2)
- PIX_W, 8, bits per pixel
- ROM_LAT, 1, ROM read latency in cycles (1..4)
- Derived constants:
  - OW = IMG_W/2
  - OH = IMG_H/2
  - RA_W = clog2(IMG_W*IMG_H)
  - WA_W = clog2(OW*OH)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run_i  in  1  level from the controller; a 0->1 transition starts a frame
- busy_o  out  1  high while a frame is in progress
- done_o  out  1  one-cycle pulse after the last RAM write
- rom_rd_en_o  out  1  ROM read strobe
- rom_addr_o  out  RA_W  ROM address, y*IMG_W+x
- rom_data_i  in  PIX_W  ROM data, valid ROM_LAT cycles after rom_rd_en_o
- ram_we_o  out  1  RAM write strobe
- ram_addr_o  out  WA_W  RAM address, oy*OW+ox
- ram_data_o  out  PIX_W  downsampled pixel

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous, active-low.
  - Reset clears all state, counters and pipeline valids.
  - Every output resets to 0, and run_q resets to 0.
  - Reset mid-frame aborts the frame with no done_o.
  - After reset, a new run_i rising edge is required to start.
- Start:
  - run_q is the registered copy of run_i.
  - start = run_i & ~run_q & state==IDLE.
  - run_i held high does not retrigger, since the controller holds run high.
  - Edges during RUN/DRAIN are ignored.
- States:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after the last read is issued.
  - DRAIN -> DONE after the last write.
  - DONE -> IDLE unconditionally.
- busy_o is high in RUN and DRAIN, asserted the cycle after start is sampled.
- Read issue:
  - In RUN, one read per cycle with rom_rd_en_o=1, with no bubbles.
  - Order is ox fastest, then oy. For each (ox,oy), the quad index k=0..3 addresses:
    - k=0: (2ox, 2oy)
    - k=1: (2ox+1, 2oy)
    - k=2: (2ox, 2oy+1)
    - k=3: (2ox+1, 2oy+1)
  - Total reads = IMG_W*IMG_H.
- Return path:
  - A ROM_LAT-deep shift register carries {valid, k, write address} alongside each read.
  - On a returning datum with k=0: acc <= data. Otherwise: acc <= acc + data.
  - acc is PIX_W+2 bits wide, so no overflow.
- Write:
  - The cycle after the k=3 datum is accumulated: ram_we_o=1.
  - ram_data_o = (acc+2)>>2, round half up; the result always fits in PIX_W bits.
  - ram_addr_o is the tagged write address.
  - ram_we_o is a single-cycle strobe; address and data are registered with it.
- Latency:
  - Relative to the first read at cycle 0, the last read is at N-1, where N=IMG_W*IMG_H.
  - Last write at N+ROM_LAT.
  - done_o at N+ROM_LAT+1, in the DONE state.
  - busy_o falls in the same cycle done_o rises.
- Counters:
  - k wraps 3->0.
  - ox wraps OW-1->0 and increments oy.
  - oy==OH-1 with ox==OW-1 and k==3 marks the last read.
  - Counters clear on entering RUN.
- Simultaneous events: a run_i rising edge in the DONE cycle is ignored; run_i must fall and rise again.

Decomposition:
- Package ds_pkg:
  - State enum: IDLE, RUN, DRAIN, DONE.
  - Function clog2.
  - Rounding constant 2.
- One sub-module: ds_tag_pipe, the parameterised ROM_LAT-deep shift register for {valid, k, waddr}.

Test Plan:
1. IMG_W=IMG_H=4, ROM_LAT=1, ROM[a]=a, pulse run_i.
   - Required: 16 consecutive reads at addresses 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
   - Required: writes addr0=3, addr1=5, addr2=11, addr3=13.
   - Required: done_o 1 cycle at cycle 18.
2. ROM all 255 -> every write is 255 (no overflow). ROM all 1 except one 2 per quad (sum 5) -> writes 1; sum 6 -> writes 2 (round half up).
3. Hold run_i high after done_o for 100 cycles -> no further reads, busy_o=0. Drop run_i, raise it again -> the frame repeats identically.
4. ROM_LAT=3 with test 1 stimulus -> same write values, last write at cycle 19, done_o at cycle 20.
5. Assert rst_n low at read 7, then release -> all outputs 0 immediately and no done_o. A new run_i edge produces a complete, correct frame.
6. Toggle run_i mid-frame -> ignored; exactly 4 writes and 1 done_o.

Source files
------------

// File: rtl/ds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ds_pkg
//  Purpose  : Shared types and helpers for the 2x2 box-filter downsampler.
//             Provides the engine state enum, a width helper for the derived
//             address widths, and the rounding offset used by the averager.
//  Revision : 1.0 - initial release
// ============================================================================
package ds_pkg;

    // Engine sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ds_state_e;

    // Added to the 4-pixel sum before the divide-by-4 so that a result
    // exactly halfway between two integers rounds up.
    localparam int c_round = 2;

    // Ceiling log2. Never returns 0, so a degenerate 1-entry space still
    // gets a 1-bit address instead of a zero-width vector.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ds_if.sv
`default_nettype none
// ============================================================================
//  Module   : ds_if
//  Purpose  : Bundles the downsampler's run/busy/done handshake, its ROM read
//             port and its frame-RAM write port.
//  Ports    : run_i        controller run level (0->1 starts a frame)
//             busy_o       frame in progress
//             done_o       one-cycle completion pulse
//             rom_rd_en_o  ROM read strobe
//             rom_addr_o   ROM address (y*IMG_W + x)
//             rom_data_i   ROM read data, ROM_LAT cycles after the strobe
//             ram_we_o     RAM write strobe
//             ram_addr_o   RAM address (oy*OW + ox)
//             ram_data_o   averaged pixel
//  Modports : slave  - the engine
//             master - controller / memories side
//  Revision : 1.0 - initial release
// ============================================================================
interface ds_if #(
    parameter int PIX_W = 8,
    parameter int RA_W  = 12,
    parameter int WA_W  = 10
);
    logic             run_i;
    logic             busy_o;
    logic             done_o;
    logic             rom_rd_en_o;
    logic [RA_W-1:0]  rom_addr_o;
    logic [PIX_W-1:0] rom_data_i;
    logic             ram_we_o;
    logic [WA_W-1:0]  ram_addr_o;
    logic [PIX_W-1:0] ram_data_o;

    modport slave (
        input  run_i,
        input  rom_data_i,
        output busy_o,
        output done_o,
        output rom_rd_en_o,
        output rom_addr_o,
        output ram_we_o,
        output ram_addr_o,
        output ram_data_o
    );

    modport master (
        output run_i,
        output rom_data_i,
        input  busy_o,
        input  done_o,
        input  rom_rd_en_o,
        input  rom_addr_o,
        input  ram_we_o,
        input  ram_addr_o,
        input  ram_data_o
    );
endinterface
`default_nettype wire

// File: rtl/ds_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ds_tag_pipe
//  Purpose  : DEPTH-stage shift register that carries the per-read tag
//             {valid, k, write address} so it emerges in the same cycle as
//             the matching ROM datum.
//  Ports    : clk    system clock
//             rst_n  asynchronous active-low reset (clears every stage)
//             tag_i  tag of the read presented this cycle
//             tag_o  tag delayed by DEPTH cycles
//  Revision : 1.0 - initial release
// ============================================================================
module ds_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o
);

    logic [TAG_W-1:0] stage_q [DEPTH];
    logic [TAG_W-1:0] stage_d [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_d[i] = tag_i;
        end else begin : g_tail
            assign stage_d[i] = stage_q[i-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ds_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ds_engine
//  Purpose  : 2x2 box-filter downsampler. On a rising edge of run_i it streams
//             the IMG_W x IMG_H source image out of the pixel ROM quad by
//             quad, averages each 2x2 quad with round-half-up and writes the
//             OW x OH result into the frame RAM, then pulses done_o.
//  Ports    : clk    system clock
//             rst_n  asynchronous active-low reset
//             bus    ds_if.slave: run/busy/done handshake, ROM read port,
//                    RAM write port
//  Revision : 1.0 - initial release
// ============================================================================
module ds_engine
    import ds_pkg::*;
#(
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int PIX_W   = 8,
    parameter int ROM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    ds_if.slave  bus
);

    localparam int OW    = IMG_W / 2;
    localparam int OH    = IMG_H / 2;
    localparam int RA_W  = clog2(IMG_W * IMG_H);
    localparam int WA_W  = clog2(OW * OH);
    localparam int OX_W  = clog2(OW);
    localparam int OY_W  = clog2(OH);
    localparam int ACC_W = PIX_W + 2;
    localparam int TAG_W = 3 + WA_W;

    localparam logic [OX_W-1:0] c_ox_last = OX_W'(OW - 1);
    localparam logic [OY_W-1:0] c_oy_last = OY_W'(OH - 1);
    localparam logic [WA_W-1:0] c_wa_last = WA_W'(OW * OH - 1);

    ds_state_e        state_q,    state_d;
    logic             run_q,      run_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic             rd_en_q,    rd_en_d;
    logic [RA_W-1:0]  rom_addr_q, rom_addr_d;
    logic [1:0]       k_q,        k_d;
    logic [OX_W-1:0]  ox_q,       ox_d;
    logic [OY_W-1:0]  oy_q,       oy_d;
    logic [WA_W-1:0]  wa_q,       wa_d;
    logic [ACC_W-1:0] acc_q,      acc_d;
    logic             ram_we_q,   ram_we_d;
    logic [WA_W-1:0]  ram_addr_q, ram_addr_d;
    logic [PIX_W-1:0] ram_data_q, ram_data_d;

    logic             w_start;
    logic             w_last_rd;
    logic [TAG_W-1:0] w_tag;
    logic             w_tp_v;
    logic [1:0]       w_tp_k;
    logic [WA_W-1:0]  w_tp_wa;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_rnd_sum;
    logic [PIX_W-1:0] w_avg;

    // ------------------------------------------------------------------------
    // The read counters always describe the read currently on the ROM port,
    // so the tag entering the pipe is simply the registered read state.
    // ------------------------------------------------------------------------
    ds_tag_pipe #(
        .DEPTH (ROM_LAT),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i ({rd_en_q, k_q, wa_q}),
        .tag_o (w_tag)
    );

    assign w_tp_v  = w_tag[TAG_W-1];
    assign w_tp_k  = w_tag[TAG_W-2 -: 2];
    assign w_tp_wa = w_tag[WA_W-1:0];

    assign w_start   = bus.run_i & ~run_q & (state_q == IDLE);
    assign w_last_rd = (k_q == 2'd3) && (ox_q == c_ox_last) && (oy_q == c_oy_last);

    // k=0 restarts the accumulation, so the previous quad's sum is dropped.
    assign w_sum     = ((w_tp_k == 2'd0) ? '0 : acc_q) + ACC_W'(bus.rom_data_i);
    assign w_rnd_sum = w_sum + ACC_W'(c_round);
    assign w_avg     = PIX_W'(w_rnd_sum >> 2);

    always_comb begin
        state_d    = state_q;
        run_d      = bus.run_i;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        k_d        = k_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        wa_d       = wa_q;
        acc_d      = acc_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;

        unique case (state_q)
            IDLE: begin
                if (w_start) begin
                    // The first read goes out together with busy.
                    state_d = RUN;
                    busy_d  = 1'b1;
                    rd_en_d = 1'b1;
                    k_d     = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                    wa_d    = '0;
                end
            end
            RUN: begin
                if (w_last_rd) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                    k_d     = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        wa_d = wa_q + WA_W'(1);
                        if (ox_q == c_ox_last) begin
                            ox_d = '0;
                            oy_d = oy_q + OY_W'(1);
                        end else begin
                            ox_d = ox_q + OX_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                // Completion is keyed on the final RAM write being on the bus.
                if (ram_we_q && (ram_addr_q == c_wa_last)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Quad index k selects the pixel: bit0 -> x offset, bit1 -> y offset.
        rom_addr_d = RA_W'({oy_d, k_d[1]}) * RA_W'(IMG_W) + RA_W'({ox_d, k_d[0]});

        if (w_tp_v) begin
            acc_d = w_sum;
            if (w_tp_k == 2'd3) begin
                ram_we_d   = 1'b1;
                ram_addr_d = w_tp_wa;
                ram_data_d = w_avg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rom_addr_q <= '0;
            k_q        <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            wa_q       <= '0;
            acc_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rom_addr_q <= rom_addr_d;
            k_q        <= k_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            wa_q       <= wa_d;
            acc_q      <= acc_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.rom_rd_en_o = rd_en_q;
    assign bus.rom_addr_o  = rom_addr_q;
    assign bus.ram_we_o    = ram_we_q;
    assign bus.ram_addr_o  = ram_addr_q;
    assign bus.ram_data_o  = ram_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ds_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ds_engine
//  Purpose  : Directed self-checking bench for ds_engine on a 4x4 image, with
//             one instance at ROM_LAT=1 and one at ROM_LAT=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ds_engine;

    logic clk;
    logic rst_n;
    logic run1;
    logic run3;
    int   sel;
    int   cyc;
    int   n_total;
    int   n_bad;

    logic [7:0] rom_mem [16];
    logic [7:0] d1_1, d3_1, d3_2, d3_3;

    int exp_rd [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    int rd_addr[$], rd_cyc[$], rd_busy[$];
    int wr_addr[$], wr_data[$], wr_cyc[$];
    int dn_cyc[$],  dn_busy[$];

    ds_if #(.PIX_W(8), .RA_W(4), .WA_W(2)) b1 ();
    ds_if #(.PIX_W(8), .RA_W(4), .WA_W(2)) b3 ();

    ds_engine #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ROM_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    ds_engine #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .ROM_LAT(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    assign b1.run_i      = run1;
    assign b3.run_i      = run3;
    assign b1.rom_data_i = d1_1;
    assign b3.rom_data_i = d3_3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: 1 and 3 cycles of read latency.
    always @(posedge clk) begin
        d1_1 <= rom_mem[b1.rom_addr_o];
        d3_1 <= rom_mem[b3.rom_addr_o];
        d3_2 <= d3_1;
        d3_3 <= d3_2;
    end

    logic       m_rd, m_we, m_done, m_busy;
    logic [3:0] m_rom_addr;
    logic [1:0] m_ram_addr;
    logic [7:0] m_ram_data;

    assign m_rd       = (sel == 3) ? b3.rom_rd_en_o : b1.rom_rd_en_o;
    assign m_we       = (sel == 3) ? b3.ram_we_o    : b1.ram_we_o;
    assign m_done     = (sel == 3) ? b3.done_o      : b1.done_o;
    assign m_busy     = (sel == 3) ? b3.busy_o      : b1.busy_o;
    assign m_rom_addr = (sel == 3) ? b3.rom_addr_o  : b1.rom_addr_o;
    assign m_ram_addr = (sel == 3) ? b3.ram_addr_o  : b1.ram_addr_o;
    assign m_ram_data = (sel == 3) ? b3.ram_data_o  : b1.ram_data_o;

    always @(negedge clk) begin
        if (m_rd) begin
            rd_addr.push_back(int'(m_rom_addr));
            rd_cyc.push_back(cyc);
            rd_busy.push_back(int'(m_busy));
        end
        if (m_we) begin
            wr_addr.push_back(int'(m_ram_addr));
            wr_data.push_back(int'(m_ram_data));
            wr_cyc.push_back(cyc);
        end
        if (m_done) begin
            dn_cyc.push_back(cyc);
            dn_busy.push_back(int'(m_busy));
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rd_addr.delete(); rd_cyc.delete(); rd_busy.delete();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        dn_cyc.delete();  dn_busy.delete();
    endtask

    task automatic set_run(input int s, input logic v);
        if (s == 3) run3 = v;
        else        run1 = v;
    endtask

    // mode 0: ROM[a]=a; 1: all 255; 2: all 1, k=0 pixel 2; 3: all 1, k=0,1 pixels 2
    task automatic fill(input int mode);
        for (int a = 0; a < 16; a++) begin
            case (mode)
                0:       rom_mem[a] = 8'(a);
                1:       rom_mem[a] = 8'd255;
                2:       rom_mem[a] = ((a % 2 == 0) && ((a / 4) % 2 == 0)) ? 8'd2 : 8'd1;
                default: rom_mem[a] = (((a / 4) % 2) == 0) ? 8'd2 : 8'd1;
            endcase
        end
    endtask

    function automatic int quad_exp(input int q);
        int ox, oy, s;
        ox = q % 2;
        oy = q / 2;
        s  = int'(rom_mem[(2*oy)*4 + 2*ox])   + int'(rom_mem[(2*oy)*4 + 2*ox + 1])
           + int'(rom_mem[(2*oy+1)*4 + 2*ox]) + int'(rom_mem[(2*oy+1)*4 + 2*ox + 1]);
        return (s + 2) / 4;
    endfunction

    // Raises run on instance s and waits (bounded) for done; leaves run high.
    task automatic run_frame(input int s, input bit toggle);
        sel = s;
        clear_log();
        set_run(s, 1'b1);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (dn_cyc.size() > 0) break;
            if (toggle && (c == 5))  set_run(s, 1'b0);
            if (toggle && (c == 7))  set_run(s, 1'b1);
            if (toggle && (c == 10)) set_run(s, 1'b0);
            if (toggle && (c == 11)) set_run(s, 1'b1);
        end
        chk("done_seen", (dn_cyc.size() > 0) ? 1 : 0, 1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int lat);
        chk("n_reads", rd_addr.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < rd_addr.size()) begin
                chk("rd_addr", rd_addr[i], exp_rd[i]);
                chk("rd_gapless", rd_cyc[i] - rd_cyc[0], i);
            end
        end
        if (rd_busy.size() > 0) chk("busy_at_first_rd", rd_busy[0], 1);
        chk("n_writes", wr_addr.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < wr_addr.size()) begin
                chk("wr_addr", wr_addr[j], j);
                chk("wr_data", wr_data[j], quad_exp(j));
            end
        end
        if ((wr_cyc.size() > 0) && (rd_cyc.size() > 0))
            chk("last_wr_cycle", wr_cyc[wr_cyc.size()-1] - rd_cyc[0], 16 + lat);
        chk("n_done", dn_cyc.size(), 1);
        if ((dn_cyc.size() > 0) && (rd_cyc.size() > 0)) begin
            chk("done_cycle", dn_cyc[0] - rd_cyc[0], 17 + lat);
            chk("busy_at_done", dn_busy[0], 0);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        run1    = 1'b0;
        run3    = 1'b0;
        sel     = 1;
        fill(0);
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy",  int'(b1.busy_o), 0);
        chk("rst_done",  int'(b1.done_o), 0);
        chk("rst_rd_en", int'(b1.rom_rd_en_o), 0);
        chk("rst_we",    int'(b1.ram_we_o), 0);
        chk("rst_busy3", int'(b3.busy_o), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Test 1: ROM[a]=a, ROM_LAT=1
        run_frame(1, 1'b0);
        check_frame(1);
        if (wr_data.size() == 4) begin
            chk("t1_w0", wr_data[0], 3);
            chk("t1_w1", wr_data[1], 5);
            chk("t1_w2", wr_data[2], 11);
            chk("t1_w3", wr_data[3], 13);
        end

        // Test 3: run held high after done -> no retrigger
        clear_log();
        repeat (100) @(posedge clk);
        #1;
        chk("hold_no_reads", rd_addr.size(), 0);
        chk("hold_busy", int'(b1.busy_o), 0);
        run1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_frame(1, 1'b0);
        check_frame(1);
        run1 = 1'b0;

        // Test 2: saturation and rounding
        fill(1);
        repeat (2) @(posedge clk);
        #1;
        run_frame(1, 1'b0);
        check_frame(1);
        for (int j = 0; j < 4; j++) if (j < wr_data.size()) chk("avg_255", wr_data[j], 255);
        run1 = 1'b0;

        fill(2);
        repeat (2) @(posedge clk);
        #1;
        run_frame(1, 1'b0);
        for (int j = 0; j < 4; j++) if (j < wr_data.size()) chk("avg_sum5", wr_data[j], 1);
        chk("n_writes_sum5", wr_data.size(), 4);
        run1 = 1'b0;

        fill(3);
        repeat (2) @(posedge clk);
        #1;
        run_frame(1, 1'b0);
        for (int j = 0; j < 4; j++) if (j < wr_data.size()) chk("avg_sum6", wr_data[j], 2);
        chk("n_writes_sum6", wr_data.size(), 4);
        run1 = 1'b0;

        // Test 4: ROM_LAT=3
        fill(0);
        repeat (2) @(posedge clk);
        #1;
        run_frame(3, 1'b0);
        check_frame(3);
        run3 = 1'b0;

        // Test 5: reset mid-frame
        sel = 1;
        repeat (2) @(posedge clk);
        #1;
        clear_log();
        run1 = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (rd_addr.size() >= 8) break;
        end
        chk("reached_rd7", (rd_addr.size() >= 8) ? 1 : 0, 1);
        rst_n = 1'b0;
        run1  = 1'b0;
        #1;
        chk("mid_rst_busy",  int'(b1.busy_o), 0);
        chk("mid_rst_rd_en", int'(b1.rom_rd_en_o), 0);
        chk("mid_rst_addr",  int'(b1.rom_addr_o), 0);
        chk("mid_rst_we",    int'(b1.ram_we_o), 0);
        chk("mid_rst_done",  int'(b1.done_o), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_done", dn_cyc.size(), 0);
        chk("post_rst_reads", rd_addr.size(), 0);
        run_frame(1, 1'b0);
        check_frame(1);
        run1 = 1'b0;

        // Test 6: run toggled mid-frame is ignored
        repeat (2) @(posedge clk);
        #1;
        run_frame(1, 1'b1);
        check_frame(1);
        run1 = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
